// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel coordinates for renderers, plus sync/DE/RGB to the DAC.
// Sync, DE and colour are delayed PIPE_DLY pixel-enables so they line up with renderer latency.
module vga_timing_gen #(
    parameter int   H_VIS    = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_VIS    = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE_DLY = 2,
    parameter int   CNT_W    = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic [7:0]       r_in_i,
    input  logic [7:0]       g_in_i,
    input  logic [7:0]       b_in_i,
    output logic [CNT_W-1:0] hpos_o,
    output logic [CNT_W-1:0] vpos_o,
    output logic             active_o,
    output logic             line_start_o,
    output logic             frame_start_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [7:0]       r_o,
    output logic [7:0]       g_o,
    output logic [7:0]       b_o
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_pipe_dly
        $error("vga_timing_gen: PIPE_DLY must be within 1..8");
    end
    if ((2 ** CNT_W) < H_TOT || (2 ** CNT_W) < V_TOT) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too narrow for H_TOT/V_TOT");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

    logic [CNT_W-1:0]    hcnt_q, hcnt_d;
    logic [CNT_W-1:0]    vcnt_q, vcnt_d;
    logic [PIPE_DLY-1:0] hs_dly_q, hs_dly_d;
    logic [PIPE_DLY-1:0] vs_dly_q, vs_dly_d;
    logic [PIPE_DLY-1:0] act_dly_q, act_dly_d;
    logic [23:0]         rgb_q, rgb_d;

    logic active;
    logic hs_raw;
    logic vs_raw;
    logic act_pre;
    logic line_start;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (ce_i) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    assign active     = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    assign hs_raw     = ((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)) ? HS_POL : ~HS_POL;
    assign vs_raw     = ((vcnt_q >= VS_BEG) && (vcnt_q < VS_END)) ? VS_POL : ~VS_POL;
    assign line_start = ce_i & ~rst_i & (hcnt_q == '0);

    // Stage 0 of each line takes the undelayed decode; the last stage drives the DAC.
    always_comb begin
        hs_dly_d  = hs_dly_q;
        vs_dly_d  = vs_dly_q;
        act_dly_d = act_dly_q;
        if (ce_i) begin
            hs_dly_d[0]  = hs_raw;
            vs_dly_d[0]  = vs_raw;
            act_dly_d[0] = active;
            for (int i = 1; i < PIPE_DLY; i++) begin
                hs_dly_d[i]  = hs_dly_q[i-1];
                vs_dly_d[i]  = vs_dly_q[i-1];
                act_dly_d[i] = act_dly_q[i-1];
            end
        end
    end

    // Colour is registered one enable before DE, so gate it with the stage just before the output.
    if (PIPE_DLY == 1) begin : g_pre_undelayed
        assign act_pre = active;
    end else begin : g_pre_stage
        assign act_pre = act_dly_q[PIPE_DLY-2];
    end

    always_comb begin
        rgb_d = rgb_q;
        if (ce_i) begin
            rgb_d = act_pre ? {r_in_i, g_in_i, b_in_i} : 24'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            hs_dly_q  <= {PIPE_DLY{~HS_POL}};
            vs_dly_q  <= {PIPE_DLY{~VS_POL}};
            act_dly_q <= '0;
            rgb_q     <= '0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hs_dly_q  <= hs_dly_d;
            vs_dly_q  <= vs_dly_d;
            act_dly_q <= act_dly_d;
            rgb_q     <= rgb_d;
        end
    end

    assign hpos_o        = hcnt_q;
    assign vpos_o        = vcnt_q;
    assign active_o      = active;
    assign line_start_o  = line_start;
    assign frame_start_o = line_start & (vcnt_q == '0);
    assign hsync_o       = hs_dly_q[PIPE_DLY-1];
    assign vsync_o       = vs_dly_q[PIPE_DLY-1];
    assign de_o          = act_dly_q[PIPE_DLY-1];
    assign r_o           = rgb_q[23:16];
    assign g_o           = rgb_q[15:8];
    assign b_o           = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 1024x768 instance and a small 16x8 instance, both
// compared every cycle against a frame-arithmetic reference model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // default instance
    logic        rst_d = 1'b1, ce_d = 1'b1;
    logic [7:0]  ri_d = 0, gi_d = 0, bi_d = 0;
    logic [10:0] hpos_d, vpos_d;
    logic        act_d, ls_d, fs_d, hs_d, vs_d, de_d;
    logic [7:0]  r_d, g_d, b_d;

    // small instance
    logic        rst_s = 1'b1, ce_s = 1'b1;
    logic [7:0]  ri_s = 0, gi_s = 0, bi_s = 0;
    logic [10:0] hpos_s, vpos_s;
    logic        act_s, ls_s, fs_s, hs_s, vs_s, de_s;
    logic [7:0]  r_s, g_s, b_s;

    vga_timing_gen dut_d (
        .clk_i(clk), .rst_i(rst_d), .ce_i(ce_d),
        .r_in_i(ri_d), .g_in_i(gi_d), .b_in_i(bi_d),
        .hpos_o(hpos_d), .vpos_o(vpos_d), .active_o(act_d),
        .line_start_o(ls_d), .frame_start_o(fs_d),
        .hsync_o(hs_d), .vsync_o(vs_d), .de_o(de_d),
        .r_o(r_d), .g_o(g_d), .b_o(b_d)
    );

    vga_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(3), .CNT_W(11)
    ) dut_s (
        .clk_i(clk), .rst_i(rst_s), .ce_i(ce_s),
        .r_in_i(ri_s), .g_in_i(gi_s), .b_in_i(bi_s),
        .hpos_o(hpos_s), .vpos_o(vpos_s), .active_o(act_s),
        .line_start_o(ls_s), .frame_start_o(fs_s),
        .hsync_o(hs_s), .vsync_o(vs_s), .de_o(de_s),
        .r_o(r_s), .g_o(g_s), .b_o(b_s)
    );

    logic [51:0] obs_d, obs_s;
    assign obs_d = {hpos_d, vpos_d, act_d, ls_d, fs_d, hs_d, vs_d, de_d, r_d, g_d, b_d};
    assign obs_s = {hpos_s, vpos_s, act_s, ls_s, fs_s, hs_s, vs_s, de_s, r_s, g_s, b_s};

    // Model state: pixel-enables taken since reset, and colour sampled at the latest one.
    int          n_d = 0, n_s = 0;
    logic [23:0] c_d = 0, c_s = 0;

    // Expected outputs after n enables: coordinate n mod frame, delayed outputs use coordinate n-P.
    function automatic logic [51:0] model(int n, logic ce, logic rst, logic [23:0] c, int p,
                                          int hv, int hf, int hsn, int hb,
                                          int vv, int vf, int vsn, int vb,
                                          logic hp, logic vp);
        int ht, vt, h, v, m, dh, dv;
        logic act, ls, fs, hs, vs, de;
        logic [23:0] px;
        ht  = hv + hf + hsn + hb;
        vt  = vv + vf + vsn + vb;
        h   = n % ht;
        v   = (n / ht) % vt;
        act = (h < hv) && (v < vv);
        ls  = ce && !rst && (h == 0);
        fs  = ls && (v == 0);
        hs  = ~hp;
        vs  = ~vp;
        de  = 1'b0;
        px  = 24'h0;
        if (n >= p) begin
            m  = n - p;
            dh = m % ht;
            dv = (m / ht) % vt;
            hs = (dh >= hv + hf && dh < hv + hf + hsn) ? hp : ~hp;
            vs = (dv >= vv + vf && dv < vv + vf + vsn) ? vp : ~vp;
            de = (dh < hv) && (dv < vv);
            px = de ? c : 24'h0;
        end
        return {11'(h), 11'(v), act, ls, fs, hs, vs, de, px};
    endfunction

    function automatic logic [51:0] model_d();
        return model(n_d, ce_d, rst_d, c_d, 2, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0);
    endfunction

    function automatic logic [51:0] model_s();
        return model(n_s, ce_s, rst_s, c_s, 3, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1);
    endfunction

    // Advance one clock and update the model with the inputs present at that edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rst_d) begin n_d = 0; c_d = 24'h0; end
        else if (ce_d) begin n_d++; c_d = {ri_d, gi_d, bi_d}; end
        if (rst_s) begin n_s = 0; c_s = 24'h0; end
        else if (ce_s) begin n_s++; c_s = {ri_s, gi_s, bi_s}; end
    endtask

    task automatic test_reset();
        logic [51:0] e;
        rst_d = 1; rst_s = 1; ce_d = 1; ce_s = 1;
        cyc(); cyc();
        rst_d = 0; rst_s = 0;
        for (int k = 0; k < 1100; k++) begin
            cyc();
            {ri_d, gi_d, bi_d} = 24'($urandom);
            #1;
            e = model_d();
            total++;
            if (obs_d !== e) begin bad++; $display("FAIL reset_run n=%0d got=%h exp=%h", n_d, obs_d, e); end
        end
        rst_d = 1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            #1;
            e = model_d();
            total++;
            if (obs_d !== e) begin bad++; $display("FAIL reset_hold_model n=%0d got=%h exp=%h", n_d, obs_d, e); end
            total++;
            if ({hpos_d, vpos_d, hs_d, vs_d, de_d, r_d, g_d, b_d} !== {22'h0, 1'b1, 1'b1, 1'b0, 24'h0}) begin
                bad++;
                $display("FAIL reset_hold h=%0d v=%0d hs=%b vs=%b de=%b rgb=%h exp 0,0,1,1,0,0",
                         hpos_d, vpos_d, hs_d, vs_d, de_d, {r_d, g_d, b_d});
            end
        end
        rst_d = 0; ce_d = 1;
        #1;
        total++;
        if ({fs_d, ls_d} !== 2'b11) begin bad++; $display("FAIL reset_first_frame_start got fs=%b ls=%b exp 1 1", fs_d, ls_d); end
        cyc();
        #1;
        total++;
        if ({fs_d, hpos_d} !== {1'b0, 11'd1}) begin bad++; $display("FAIL reset_fs_one_cycle got fs=%b h=%0d exp fs=0 h=1", fs_d, hpos_d); end
    endtask

    task automatic test_default_line();
        logic [51:0] e;
        logic prev_hs = 1'b0, prev_de = 1'b1;
        bit   seen_hs = 0, seen_de = 0;
        int   lo_run = 0, de_run = 0, last_fall = 0;
        ce_d = 1;
        for (int k = 0; k < 4300; k++) begin
            cyc();
            ce_d = 1;
            #1;
            e = model_d();
            total++;
            if (obs_d !== e) begin bad++; $display("FAIL line_model n=%0d got=%h exp=%h", n_d, obs_d, e); end
            if (!hs_d) begin
                if (prev_hs) begin
                    if (seen_hs) begin
                        total++;
                        if (k - last_fall != 1344) begin bad++; $display("FAIL hsync_period got=%0d exp=1344", k - last_fall); end
                    end
                    seen_hs = 1; last_fall = k; lo_run = 0;
                end
                lo_run++;
            end else if (!prev_hs && seen_hs) begin
                total++;
                if (lo_run != 136) begin bad++; $display("FAIL hsync_width got=%0d exp=136", lo_run); end
            end
            prev_hs = hs_d;
            if (de_d) begin
                if (!prev_de) begin seen_de = 1; de_run = 0; end
                de_run++;
            end else if (prev_de && seen_de) begin
                total++;
                if (de_run != 1024) begin bad++; $display("FAIL de_width got=%0d exp=1024", de_run); end
            end
            prev_de = de_d;
        end
    endtask

    task automatic test_ce_toggle();
        logic [51:0] e;
        logic prev_hs = 1'b0, edge_ce;
        bit   seen_hs = 0;
        int   lo_run = 0, last_fall = 0, h_ref;
        h_ref = n_d % 1344;
        for (int k = 0; k < 5800; k++) begin
            cyc();
            edge_ce = ce_d;
            ce_d = (k % 2 == 0);
            #1;
            if (edge_ce) h_ref = (h_ref + 1) % 1344;
            total++;
            if (32'(hpos_d) !== h_ref) begin bad++; $display("FAIL ce_hpos got=%0d exp=%0d", hpos_d, h_ref); end
            total++;
            if ((ls_d | fs_d) & ~ce_d) begin bad++; $display("FAIL ce_pulse got ls=%b fs=%b exp 0 0 with ce=0", ls_d, fs_d); end
            e = model_d();
            total++;
            if (obs_d !== e) begin bad++; $display("FAIL ce_model n=%0d got=%h exp=%h", n_d, obs_d, e); end
            if (!hs_d) begin
                if (prev_hs) begin
                    if (seen_hs) begin
                        total++;
                        if (k - last_fall != 2688) begin bad++; $display("FAIL ce_hsync_period got=%0d exp=2688", k - last_fall); end
                    end
                    seen_hs = 1; last_fall = k; lo_run = 0;
                end
                lo_run++;
            end else if (!prev_hs && seen_hs) begin
                total++;
                if (lo_run != 272) begin bad++; $display("FAIL ce_hsync_width got=%0d exp=272", lo_run); end
            end
            prev_hs = hs_d;
        end
        ce_d = 1;
    endtask

    task automatic test_small_random();
        logic [51:0] e;
        rst_s = 1;
        cyc(); cyc();
        rst_s = 0;
        for (int k = 0; k < 700; k++) begin
            cyc();
            ce_s = ($urandom_range(0, 3) != 0);
            {ri_s, gi_s, bi_s} = 24'($urandom);
            #1;
            e = model_s();
            total++;
            if (obs_s !== e) begin bad++; $display("FAIL small_random n=%0d got=%h exp=%h", n_s, obs_s, e); end
        end
    endtask

    task automatic test_small_render();
        logic [51:0] e;
        logic [7:0]  p1, p2;
        rst_s = 1; ce_s = 1; ri_s = 0; gi_s = 0; bi_s = 0;
        cyc(); cyc();
        rst_s = 0;
        #1;
        p1 = hpos_s[7:0]; p2 = 8'h0;
        for (int k = 0; k < 260; k++) begin
            cyc();
            ri_s = p2; p2 = p1; p1 = hpos_s[7:0];
            #1;
            e = model_s();
            total++;
            if (obs_s !== e) begin bad++; $display("FAIL render_model n=%0d got=%h exp=%h", n_s, obs_s, e); end
            if (de_s) begin
                total++;
                if (r_s !== 8'((n_s - 3) % 16)) begin bad++; $display("FAIL render_r n=%0d got=%0d exp=%0d", n_s, r_s, (n_s - 3) % 16); end
            end
            if (n_s >= 3) begin
                total++;
                if (hs_s !== ((n_s % 16) >= 13)) begin bad++; $display("FAIL render_hsync n=%0d got=%b", n_s, hs_s); end
                total++;
                if (vs_s !== ((((n_s - 3) / 16) % 8) inside {5, 6})) begin bad++; $display("FAIL render_vsync n=%0d got=%b", n_s, vs_s); end
            end
        end
    endtask

    task automatic test_blanking();
        logic [51:0] e;
        ce_s = 1; ri_s = 8'hFF; gi_s = 8'hFF; bi_s = 8'hFF;
        for (int k = 0; k < 200; k++) begin
            cyc();
            #1;
            total++;
            if ({r_s, g_s, b_s} !== (de_s ? 24'hFFFFFF : 24'h0)) begin
                bad++;
                $display("FAIL blanking n=%0d de=%b got=%h", n_s, de_s, {r_s, g_s, b_s});
            end
            e = model_s();
            total++;
            if (obs_s !== e) begin bad++; $display("FAIL blanking_model n=%0d got=%h exp=%h", n_s, obs_s, e); end
        end
    endtask

    task automatic test_wrap();
        ce_s = 1;
        for (int k = 0; k < 200 && (n_s % 128) != 127; k++) cyc();
        #1;
        total++;
        if ({hpos_s, vpos_s} !== {11'd15, 11'd7}) begin
            bad++;
            $display("FAIL wrap_last got h=%0d v=%0d exp h=15 v=7", hpos_s, vpos_s);
        end
        cyc();
        #1;
        total++;
        if ({hpos_s, vpos_s, fs_s, ls_s} !== {22'h0, 2'b11}) begin
            bad++;
            $display("FAIL wrap_next got h=%0d v=%0d fs=%b ls=%b exp 0 0 1 1", hpos_s, vpos_s, fs_s, ls_s);
        end
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_ce_toggle();
        test_small_random();
        test_small_render();
        test_blanking();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
